serial_cmp_ctrl: RTL
====================

SERIAL_CMP_CTRL -- requirements
Module: serial_cmp_ctrl

Interface
REQ-001 SHALL have parameter MAX_CHUNKS, default 8, giving the maximum 3-bit chunks per operand (legal range 1..64).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: a chunk pair is presented.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a chunk this cycle; a beat is accepted when in_valid and in_ready are both high.
REQ-006 SHALL have port in_first, input, 1 bit: the beat is the least-significant chunk of a new operand pair.
REQ-007 SHALL have port in_last, input, 1 bit: the beat is the most-significant chunk.
REQ-008 SHALL have ports a_chunk and b_chunk, input, 3 bits each: operand chunks, streamed LSB chunk first.
REQ-009 SHALL have ports res_lt, res_eq and res_gt, output, 1 bit each: the registered final comparison of A versus B, one-hot.
REQ-010 SHALL have port res_valid, output, 1 bit: one-cycle pulse when res_* are updated.
REQ-011 SHALL have port err, output, 1 bit: one-cycle pulse on a protocol error or overflow.

Function
REQ-012 SHALL implement states IDLE, RUN and DONE; in_ready SHALL be 1 in IDLE and RUN and 0 in DONE.
REQ-013 SHALL hold cascade state {l,e,g} as a one-hot register.
- Per accepted beat, next cascade = gt if a_chunk>b_chunk; lt if a_chunk<b_chunk; otherwise the previous cascade.
- A higher chunk overrides lower-chunk history.
REQ-014 SHALL, on an accepted in_first beat, use {l,e,g}={0,1,0} as the previous cascade, clear the chunk count, then apply REQ-013.
REQ-015 SHALL go IDLE->RUN on an accepted beat with in_first=1 and in_last=0.
REQ-016 SHALL go IDLE->DONE on an accepted beat with in_first=1 and in_last=1; this is a single-chunk compare.
REQ-017 SHALL, in IDLE, discard an accepted beat with in_first=0, pulse err, and stay in IDLE.
REQ-018 SHALL, in RUN, treat an accepted beat with in_first=1 as an abort-and-restart: discard the prior cascade, apply REQ-014, and produce no err.
REQ-019 SHALL go RUN->DONE on an accepted beat with in_last=1.
REQ-020 SHALL count accepted chunks; the counter width is ceil(log2(MAX_CHUNKS+1)) bits.
REQ-021 SHALL, if a beat would be chunk MAX_CHUNKS+1, discard it, pulse err, go to IDLE, and leave res_* unchanged.
REQ-022 SHALL, on entry to DONE, load res_lt/res_eq/res_gt from the final cascade and pulse res_valid for exactly one cycle.
- Latency: res_valid is asserted the cycle after the in_last beat is accepted.
REQ-023 SHALL go DONE->IDLE unconditionally after one cycle.
REQ-024 SHALL hold res_* stable between res_valid pulses.
REQ-025 SHALL ignore in_first, in_last and chunk inputs when in_valid=0 or in_ready=0.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, apply the following reset values:
- state = IDLE;
- cascade = {0,1,0};
- chunk count = 0;
- res_lt=0, res_eq=1, res_gt=0;
- res_valid=0 and err=0.
REQ-027 SHALL abandon any in-progress operation when reset is asserted mid-stream, with no res_valid and no err pulse.
REQ-028 SHALL give rst priority over every other event in the same cycle.

Configuration
REQ-029 SHALL, when macro SERIAL_CMP_CHUNK_COUNT_EN is defined, add an output port res_count, with width per REQ-020.
- res_count is loaded with the number of chunks in the compared operands, at the same time as res_*.
- res_count resets to 0.
REQ-030 SHALL, without SERIAL_CMP_CHUNK_COUNT_EN, omit res_count; all other behaviour is identical.

Verification
REQ-031 SHALL cover a two-chunk compare: A=0o57, B=0o47 (beats {7,7}, then {5,4}) -> res_gt=1 and res_valid pulses one cycle after the last beat.
REQ-032 SHALL cover a low chunk overridden by a high chunk: beats {7,0} then {2,3} -> res_lt=1; and three equal chunks {3,3} -> res_eq=1.
REQ-033 SHALL cover a single beat with in_first=1, in_last=1, {1,6} -> state DONE, res_lt=1, in_ready=0 for that one cycle, then IDLE.
REQ-034 SHALL cover MAX_CHUNKS=2 with a third beat and no in_last -> err pulse, state IDLE, res_* unchanged; a beat without in_first in IDLE -> err pulse.
REQ-035 SHALL cover restart and reset mid-stream:
- in_first mid-RUN -> restart with no err;
- rst asserted mid-RUN -> res_eq=1 and no res_valid pulse.
REQ-036 SHALL, with SERIAL_CMP_CHUNK_COUNT_EN defined, check that a 5-chunk stream gives res_count=5 together with res_valid.

Source files
------------

// File: rtl/serial_cmp_ctrl.sv
// Serial magnitude comparator: streams 3-bit chunk pairs LSB first, reports A<B / A==B / A>B.
// Optional macro SERIAL_CMP_CHUNK_COUNT_EN adds the res_count output.
module serial_cmp_ctrl #(
    parameter int MAX_CHUNKS = 8,
    localparam int CW = $clog2(MAX_CHUNKS + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_first,
    input  logic       in_last,
    input  logic [2:0] a_chunk,
    input  logic [2:0] b_chunk,
    output logic       res_lt,
    output logic       res_eq,
    output logic       res_gt,
    output logic       res_valid,
    output logic       err
`ifdef SERIAL_CMP_CHUNK_COUNT_EN
    ,
    output logic [CW-1:0] res_count
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0]    CASC_EQ = 3'b010;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CHUNKS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t        state_q, state_d;
    logic [2:0]    casc_q, casc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    res_q, res_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic          rv_q, rv_d;
    logic          err_q, err_d;
    logic          accept;

    // Cascade is {l,e,g}; a strictly differing chunk overrides all lower-chunk history.
    function automatic logic [2:0] cascade(input logic [2:0] prev,
                                           input logic [2:0] a,
                                           input logic [2:0] b);
        if (a > b)      return 3'b001;
        else if (a < b) return 3'b100;
        else            return prev;
    endfunction

    assign in_ready = (state_q != DONE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        casc_d  = casc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        rcnt_d  = rcnt_q;
        rv_d    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE, RUN: begin
                if (accept) begin
                    if (in_first) begin
                        casc_d  = cascade(CASC_EQ, a_chunk, b_chunk);
                        cnt_d   = CNT_ONE;
                        state_d = in_last ? DONE : RUN;
                    end else if (state_q == IDLE) begin
                        err_d = 1'b1;
                    end else if (cnt_q == CNT_MAX) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        casc_d  = cascade(casc_q, a_chunk, b_chunk);
                        cnt_d   = cnt_q + CNT_ONE;
                        state_d = in_last ? DONE : RUN;
                    end
                    if (state_d == DONE) begin
                        res_d  = casc_d;
                        rcnt_d = cnt_d;
                        rv_d   = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            casc_q  <= CASC_EQ;
            cnt_q   <= '0;
            res_q   <= CASC_EQ;
            rcnt_q  <= '0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            casc_q  <= casc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            rcnt_q  <= rcnt_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
        end
    end

    assign res_lt    = res_q[2];
    assign res_eq    = res_q[1];
    assign res_gt    = res_q[0];
    assign res_valid = rv_q;
    assign err       = err_q;

`ifdef SERIAL_CMP_CHUNK_COUNT_EN
    assign res_count = rcnt_q;
`else
    logic unused_rcnt;
    assign unused_rcnt = ^rcnt_q;
`endif

endmodule
